// File: rtl/sar_conv_ctrl.sv
// Sequencer for a SAR ADC core: runs 2^avg_log2 conversions per request,
// accumulates the results and presents the truncated mean on a valid/ready port.
module sar_conv_ctrl #(
   parameter int unsigned NBITS       = 11,
   parameter int unsigned CONV_CYCLES = 13
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       avg_log2,
   input  logic [NBITS-1:0] sar_result,
   output logic             sar_rst_n,
   output logic             sar_clk_en,
   output logic             busy,
   output logic [NBITS-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned AW = NBITS + 3;
   localparam int unsigned CW = $clog2(CONV_CYCLES);
   localparam int unsigned SW = 4;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARM  = 3'd1,
      S_CONV = 3'd2,
      S_ACC  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cyc_q, cyc_d;
   logic [SW-1:0]    smp_q, smp_d;
   logic [1:0]       avg_q, avg_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [NBITS-1:0] out_data_q, out_data_d;
   logic             sar_rst_n_q, sar_rst_n_d;
   logic             sar_clk_en_q, sar_clk_en_d;
   logic             busy_q, busy_d;
   logic             out_valid_q, out_valid_d;

   logic             xfer;
   logic             last_cyc;
   logic             last_smp;
   logic [AW-1:0]    acc_sum;

   assign xfer     = (state_q == S_DONE) && out_ready;
   assign last_cyc = (cyc_q == CW'(CONV_CYCLES - 1));
   assign last_smp = ((smp_q + SW'(1)) == (SW'(1) << avg_q));
   assign acc_sum  = acc_q + AW'(sar_result);

   // State register
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_ARM;
         S_ARM:  state_d = S_CONV;
         S_CONV: if (last_cyc) state_d = S_ACC;
         S_ACC:  state_d = last_smp ? S_DONE : S_ARM;
         S_DONE: if (xfer) state_d = start ? S_ARM : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so every output leaves a flop
   always_comb begin
      sar_rst_n_d  = 1'b0;
      sar_clk_en_d = 1'b0;
      busy_d       = 1'b1;
      out_valid_d  = 1'b0;
      unique case (state_d)
         S_IDLE: busy_d = 1'b0;
         S_ARM:  ;
         S_CONV: begin
            sar_rst_n_d  = 1'b1;
            sar_clk_en_d = 1'b1;
         end
         S_ACC:  sar_rst_n_d = 1'b1;
         S_DONE: begin
            sar_rst_n_d = 1'b1;
            out_valid_d = 1'b1;
         end
         default: busy_d = 1'b0;
      endcase
   end

   // Counters, accumulator and result register
   always_comb begin
      cyc_d      = cyc_q;
      smp_d      = smp_q;
      avg_d      = avg_q;
      acc_d      = acc_q;
      out_data_d = out_data_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               avg_d = avg_log2;
               acc_d = '0;
               smp_d = '0;
            end
         end
         S_ARM:  cyc_d = '0;
         S_CONV: cyc_d = cyc_q + CW'(1);
         S_ACC: begin
            acc_d = acc_sum;
            smp_d = smp_q + SW'(1);
            if (last_smp) out_data_d = NBITS'(acc_sum >> avg_q);
         end
         S_DONE: begin
            if (xfer && start) begin
               avg_d = avg_log2;
               acc_d = '0;
               smp_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cyc_q        <= '0;
         smp_q        <= '0;
         avg_q        <= '0;
         acc_q        <= '0;
         out_data_q   <= '0;
         sar_rst_n_q  <= 1'b0;
         sar_clk_en_q <= 1'b0;
         busy_q       <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         cyc_q        <= cyc_d;
         smp_q        <= smp_d;
         avg_q        <= avg_d;
         acc_q        <= acc_d;
         out_data_q   <= out_data_d;
         sar_rst_n_q  <= sar_rst_n_d;
         sar_clk_en_q <= sar_clk_en_d;
         busy_q       <= busy_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign sar_rst_n  = sar_rst_n_q;
   assign sar_clk_en = sar_clk_en_q;
   assign busy       = busy_q;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Bench for sar_conv_ctrl: a burst-timeline reference model checked every cycle,
// directed bursts with literal expectations, then randomized traffic.
module tb_sar_conv_ctrl;

   localparam int unsigned NB = 11;
   localparam int unsigned CC = 13;
   localparam int          P  = CC + 2;

   logic          clock;
   logic          reset_n;
   logic          start;
   logic [1:0]    avg_log2;
   logic [NB-1:0] sar_result;
   logic          sar_rst_n;
   logic          sar_clk_en;
   logic          busy;
   logic [NB-1:0] out_data;
   logic          out_valid;
   logic          out_ready;

   int n_pass = 0;
   int n_tot  = 0;

   logic [NB-1:0] vals [8];

   sar_conv_ctrl #(.NBITS(NB), .CONV_CYCLES(CC)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .avg_log2   (avg_log2),
      .sar_result (sar_result),
      .sar_rst_n  (sar_rst_n),
      .sar_clk_en (sar_clk_en),
      .busy       (busy),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: a burst is a timeline of edges since acceptance; each sample
   // occupies P edges and its result is taken on the edge closing that window.
   bit            m_ok = 0;
   bit            m_busy, m_valid;
   int            m_e, m_avg;
   longint        m_sum;
   logic [NB-1:0] m_data;

   always begin
      int  p;
      bit  e_rst, e_en;
      @(posedge clock);
      if (!reset_n) begin
         m_busy = 0; m_valid = 0; m_data = '0; m_ok = 1;
      end else if (m_valid) begin
         if (out_ready) begin
            m_valid = 0;
            m_busy  = start;
            if (start) begin m_e = 0; m_avg = int'(avg_log2); m_sum = 0; end
         end
      end else if (m_busy) begin
         m_e++;
         if (m_e % P == 0) begin
            m_sum += longint'(sar_result);
            if (m_e == P * (1 << m_avg)) begin
               m_valid = 1;
               m_data  = NB'(m_sum >> m_avg);
            end
         end
      end else if (start) begin
         m_busy = 1; m_e = 0; m_avg = int'(avg_log2); m_sum = 0;
      end
      #1;
      if (m_ok) begin
         if (!m_busy)      begin e_rst = 0; e_en = 0; end
         else if (m_valid) begin e_rst = 1; e_en = 0; end
         else begin
            p     = m_e % P;
            e_rst = (p != 0);
            e_en  = (p >= 1) && (p <= P - 2);
         end
         check("model_busy",     32'(busy),       32'(m_busy));
         check("model_valid",    32'(out_valid),  32'(m_valid));
         check("model_sar_rstn", 32'(sar_rst_n),  32'(e_rst));
         check("model_clk_en",   32'(sar_clk_en), 32'(e_en));
         check("model_out_data", 32'(out_data),   32'(m_data));
      end
   end

   // Start a burst and run until out_valid is seen or the budget expires.
   task automatic do_burst(input logic [1:0] avg, input logic rdy, input int poke_e,
                           output int lat, output logic [NB-1:0] data,
                           output int en_cnt, output int arm_cnt);
      int e;
      @(negedge clock);
      start = 1'b1; avg_log2 = avg; out_ready = rdy;
      e = 0; lat = -1; data = '0; en_cnt = 0; arm_cnt = 0;
      while (lat < 0 && e <= P * 8 + 5) begin
         @(posedge clock); #1;
         if (sar_clk_en) en_cnt++;
         if (busy && !sar_rst_n) arm_cnt++;
         if (out_valid) begin
            lat  = e;
            data = out_data;
         end else begin
            @(negedge clock);
            start    = (e + 1 == poke_e);
            avg_log2 = 2'($urandom);
            if (e / P < 8) sar_result = vals[e / P];
            e++;
         end
      end
   endtask

   initial begin
      int            lat, en_cnt, arm_cnt;
      logic [NB-1:0] d;
      reset_n = 1'b0; start = 1'b0; avg_log2 = '0; sar_result = '0; out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_busy",     32'(busy),       32'd0);
      check("rst_valid",    32'(out_valid),  32'd0);
      check("rst_data",     32'(out_data),   32'd0);
      check("rst_sar_rstn", 32'(sar_rst_n),  32'd0);
      check("rst_clk_en",   32'(sar_clk_en), 32'd0);
      @(negedge clock); reset_n = 1'b1;

      // Single conversion
      vals[0] = 11'h5A3;
      do_burst(2'd0, 1'b1, -1, lat, d, en_cnt, arm_cnt);
      check("single_latency", 32'(lat),    32'd15);
      check("single_data",    32'(d),      32'h5A3);
      check("single_clk_en",  32'(en_cnt), 32'd13);
      @(negedge clock); start = 1'b0;
      @(posedge clock); #1;
      check("single_one_valid", 32'(out_valid), 32'd0);
      check("single_idle",      32'(busy),      32'd0);

      // Four-sample average
      vals[0] = 11'h400; vals[1] = 11'h401; vals[2] = 11'h402; vals[3] = 11'h405;
      do_burst(2'd2, 1'b1, -1, lat, d, en_cnt, arm_cnt);
      check("avg4_latency", 32'(lat),     32'd60);
      check("avg4_data",    32'(d),       32'h402);
      check("avg4_arms",    32'(arm_cnt), 32'd4);
      @(negedge clock); start = 1'b0;
      repeat (2) @(negedge clock);

      // Full scale, then truncation
      for (int i = 0; i < 8; i++) vals[i] = 11'h7FF;
      do_burst(2'd3, 1'b1, -1, lat, d, en_cnt, arm_cnt);
      check("full_latency", 32'(lat), 32'd120);
      check("full_data",    32'(d),   32'h7FF);
      @(negedge clock); start = 1'b0;
      for (int i = 0; i < 8; i++) vals[i] = NB'(i % 2);
      do_burst(2'd3, 1'b1, -1, lat, d, en_cnt, arm_cnt);
      check("trunc_data", 32'(d), 32'h000);
      @(negedge clock); start = 1'b0;

      // Start pulsed mid-conversion is ignored
      vals[0] = 11'h123;
      do_burst(2'd0, 1'b1, 6, lat, d, en_cnt, arm_cnt);
      check("ignstart_latency", 32'(lat), 32'd15);
      check("ignstart_data",    32'(d),   32'h123);
      @(negedge clock); start = 1'b0;
      @(posedge clock); #1;
      check("ignstart_idle", 32'(busy), 32'd0);

      // Backpressure then back-to-back start
      vals[0] = 11'h100; vals[1] = 11'h203;
      do_burst(2'd1, 1'b0, -1, lat, d, en_cnt, arm_cnt);
      check("bp_latency", 32'(lat), 32'd30);
      check("bp_data",    32'(d),   32'h181);
      for (int i = 0; i < 20; i++) begin
         @(negedge clock); out_ready = 1'b0; start = 1'(i % 2);
         @(posedge clock); #1;
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_data",  32'(out_data),  32'h181);
      end
      @(negedge clock); out_ready = 1'b1; start = 1'b1; avg_log2 = 2'd0;
      @(posedge clock); #1;
      check("b2b_busy",     32'(busy),       32'd1);
      check("b2b_valid",    32'(out_valid),  32'd0);
      check("b2b_sar_rstn", 32'(sar_rst_n),  32'd0);
      @(negedge clock); start = 1'b0; sar_result = 11'h055;
      @(posedge clock); #1;
      check("b2b_conv", 32'(sar_clk_en), 32'd1);
      for (int i = 0; i < 20 && busy; i++) @(posedge clock);
      #1;
      check("b2b_done", 32'(busy), 32'd0);

      // Reset during conversion, cycle count 6
      @(negedge clock); start = 1'b1; avg_log2 = 2'd1;
      @(posedge clock);
      @(negedge clock); start = 1'b0;
      repeat (7) @(posedge clock);
      #1;
      check("midrst_in_conv", 32'(sar_clk_en), 32'd1);
      @(negedge clock); reset_n = 1'b0;
      @(posedge clock); #1;
      check("midrst_busy",     32'(busy),      32'd0);
      check("midrst_valid",    32'(out_valid), 32'd0);
      check("midrst_sar_rstn", 32'(sar_rst_n), 32'd0);
      @(negedge clock); reset_n = 1'b1;
      vals[0] = 11'h2AA;
      do_burst(2'd0, 1'b1, -1, lat, d, en_cnt, arm_cnt);
      check("midrst_latency", 32'(lat), 32'd15);
      check("midrst_data",    32'(d),   32'h2AA);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         @(negedge clock);
         start      = ($urandom % 4) == 0;
         avg_log2   = 2'($urandom);
         sar_result = NB'($urandom);
         out_ready  = ($urandom % 3) != 0;
         reset_n    = ($urandom % 300) != 0;
      end
      @(negedge clock); reset_n = 1'b1; start = 1'b0;
      repeat (2) @(posedge clock);
      #2;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
